life_loader: RTL and testbench

Parametrised seed loader and generation sequencer for the Game of Life torus. Turns UART bytes into a serial seed stream for the torus shift register, with row and board padding commands. Issues timed or single-step `life_step` pulses, then recirculates the whole torus once while writing each cell as a character into text video memory. Sits between the UART receiver, VGA sync, board buttons, the torus core and the text-mode video RAM.

---
 rtl/life_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_life_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/life_loader.sv
// life_loader: turns UART bytes into a serial seed stream for the Life torus, sequences
// generation steps and dumps each generation to text video RAM. Optional macro LIFE_STATS_EN.
module life_loader #(
  parameter int          TORUS_WIDTH  = 32,
  parameter int          TORUS_HEIGHT = 16,
  parameter int          STEP_FRAMES  = 20,
  parameter int          COL_OFFSET   = 4,
  parameter int          ROW_SHIFT    = 7,
  parameter logic [15:0] CHAR_LIVE    = 16'h4f2a,
  parameter logic [15:0] CHAR_DEAD    = 16'h1f30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  input  logic        vsync,
  input  logic        load_n,
  input  logic        pause_n,
  input  logic        step_n,
  input  logic        torus_last,
  output logic        seed,
  output logic        seed_ena,
  output logic        life_step,
  output logic [15:0] wdata,
  output logic [12:0] waddr,
  output logic        wr,
  output logic        busy,
  output logic        rx_overrun,
  output logic [15:0] gen_count,
  output logic [15:0] pop_count
);

  localparam int N     = TORUS_WIDTH * TORUS_HEIGHT;
  localparam int IDX_W = $clog2(N);
  localparam int COL_W = $clog2(TORUS_WIDTH);
  localparam int FR_W  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [IDX_W-1:0] CELL_LAST  = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(TORUS_WIDTH - 1);
  localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(STEP_FRAMES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_STEP, S_DUMP} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       vsync_sync_reg, rx_sync_reg;
  logic [2:0]       btn_sh_reg [3];
  logic [2:0]       btn_pins;
  logic [FR_W-1:0]  frame_reg;
  logic [7:0]       hold_reg;
  logic             hold_full_reg;
  logic             overrun_reg;
  logic [IDX_W-1:0] cell_reg, cell_next;
  logic             pad_board_reg, pad_board_next;

  logic vs_rise, rx_rise, load_f, pause_f, step_press, due;
  logic emit, emit_val, consume, clear, dump, capture;
  logic cell_last, col_last;
  logic [COL_W-1:0] col;
  logic [12:0] row_a, col_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_sync_reg <= '0;
      rx_sync_reg    <= '0;
    end else begin
      vsync_sync_reg <= {vsync_sync_reg[1:0], vsync};
      rx_sync_reg    <= {rx_sync_reg[1:0], rx_ready};
    end
  end

  assign vs_rise = vsync_sync_reg[1] & ~vsync_sync_reg[2];
  assign rx_rise = rx_sync_reg[1] & ~rx_sync_reg[2];

  // Buttons are debounced by sampling once per frame: index 0 load, 1 pause, 2 step.
  assign btn_pins = {step_n, pause_n, load_n};
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          btn_sh_reg[gi] <= 3'b111;
        else if (vs_rise)
          btn_sh_reg[gi] <= {btn_sh_reg[gi][1:0], btn_pins[gi]};
      end
    end
  endgenerate

  assign load_f     = btn_sh_reg[0][2];
  assign pause_f    = btn_sh_reg[1][2];
  assign step_press = vs_rise & btn_sh_reg[2][2] & ~btn_sh_reg[2][1];
  assign due        = vs_rise && (frame_reg == FRAME_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_reg <= '0;
    else if (vs_rise)
      frame_reg <= (frame_reg == FRAME_LAST) ? '0 : frame_reg + FR_W'(1);
  end

  assign col       = cell_reg[COL_W-1:0];
  assign col_last  = (col == COL_LAST);
  assign cell_last = (cell_reg == CELL_LAST);
  assign dump      = (state_reg == S_DUMP);

  always_comb begin
    state_next     = state_reg;
    pad_board_next = pad_board_reg;
    emit           = 1'b0;
    emit_val       = 1'b0;
    consume        = 1'b0;
    clear          = 1'b0;
    case (state_reg)
      S_LOAD: begin
        if (hold_full_reg) begin
          consume = 1'b1;
          case (hold_reg)
            8'h2A: begin emit = 1'b1; emit_val = 1'b1; end
            8'h2D: emit = 1'b1;
            8'h0A: if (col != '0) begin
              state_next     = S_PAD;
              pad_board_next = 1'b0;
            end
            8'h21: if (cell_reg != '0) begin
              state_next     = S_PAD;
              pad_board_next = 1'b1;
            end
            default: ;
          endcase
        end else if (load_f) begin
          state_next = S_IDLE;
        end
      end
      S_PAD: begin
        emit = 1'b1;
        if (pad_board_reg ? cell_last : col_last)
          state_next = S_LOAD;
      end
      S_IDLE: begin
        if (!load_f) begin
          state_next = S_LOAD;
          clear      = 1'b1;
        end else if ((due && pause_f) || (step_press && !pause_f)) begin
          state_next = S_STEP;
        end
      end
      S_STEP: state_next = S_DUMP;
      S_DUMP: if (cell_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The same cell counter addresses loading and the full-torus dump.
  always_comb begin
    cell_next = cell_reg;
    if (clear || state_reg == S_STEP)
      cell_next = '0;
    else if (emit || dump)
      cell_next = cell_reg + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cell_reg      <= '0;
      pad_board_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cell_reg      <= cell_next;
      pad_board_reg <= pad_board_next;
    end
  end

  assign capture = rx_rise && (state_reg == S_LOAD || state_reg == S_PAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (capture && (!hold_full_reg || consume)) begin
        hold_reg      <= rx_byte;
        hold_full_reg <= 1'b1;
      end else if (consume) begin
        hold_full_reg <= 1'b0;
      end
      if (clear)
        overrun_reg <= 1'b0;
      else if (capture && hold_full_reg && !consume)
        overrun_reg <= 1'b1;
    end
  end

  assign row_a     = 13'(cell_reg >> COL_W);
  assign col_a     = 13'(col);
  assign waddr     = (row_a << ROW_SHIFT) + col_a + 13'(COL_OFFSET);
  assign seed_ena  = emit | dump;
  assign seed      = dump ? torus_last : emit_val;
  assign wr        = seed_ena;
  assign wdata     = seed ? CHAR_LIVE : CHAR_DEAD;
  assign life_step = (state_reg == S_STEP);
  assign busy      = (state_reg == S_PAD) || (state_reg == S_STEP) || dump;
  assign rx_overrun = overrun_reg;

`ifdef LIFE_STATS_EN
  logic [15:0] gen_reg, pop_reg, pop_acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_reg     <= '0;
      pop_reg     <= '0;
      pop_acc_reg <= '0;
    end else if (clear) begin
      gen_reg <= '0;
      pop_reg <= '0;
    end else if (state_reg == S_STEP) begin
      gen_reg     <= gen_reg + 16'd1;
      pop_acc_reg <= '0;
    end else if (dump) begin
      pop_acc_reg <= pop_acc_reg + 16'(torus_last);
      if (cell_last)
        pop_reg <= pop_acc_reg + 16'(torus_last);
    end
  end

  assign gen_count = gen_reg;
  assign pop_count = pop_reg;
`else
  assign gen_count = 16'd0;
  assign pop_count = 16'd0;
`endif

endmodule

// File: tb/tb_life_loader.sv
// Scoreboard bench for life_loader on an 8x4 torus: stimulus pushes expected emissions,
// a negedge monitor pops and compares every seed_ena / life_step cycle.
module tb_life_loader;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;
  localparam logic [15:0] LIVE = 16'h4f2a;
  localparam logic [15:0] DEAD = 16'h1f30;

  typedef struct packed {
    logic        is_step;
    logic        seed;
    logic [12:0] waddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready = 1'b0;
  logic        vsync = 1'b0;
  logic        load_n = 1'b0;
  logic        pause_n = 1'b0;
  logic        step_n = 1'b1;
  logic        torus_last;
  logic        seed, seed_ena, life_step, wr, busy, rx_overrun;
  logic [15:0] wdata, gen_count, pop_count;
  logic [12:0] waddr;
  logic [N-1:0] tor = '0;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  life_loader #(
    .TORUS_WIDTH(W), .TORUS_HEIGHT(H), .STEP_FRAMES(3), .COL_OFFSET(4),
    .ROW_SHIFT(7), .CHAR_LIVE(LIVE), .CHAR_DEAD(DEAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_ready(rx_ready), .vsync(vsync),
    .load_n(load_n), .pause_n(pause_n), .step_n(step_n), .torus_last(torus_last),
    .seed(seed), .seed_ena(seed_ena), .life_step(life_step), .wdata(wdata),
    .waddr(waddr), .wr(wr), .busy(busy), .rx_overrun(rx_overrun),
    .gen_count(gen_count), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  // Torus stand-in: a plain recirculating shift register, oldest cell at the top.
  assign torus_last = tor[N-1];
  always @(posedge clk) if (seed_ena) tor <= {tor[N-2:0], seed};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int stat(input int v);
`ifdef LIFE_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic logic [12:0] addr_of(input int idx);
    return 13'(((idx / W) << 7) + (idx % W) + 4);
  endfunction

  task automatic exp_cell(input logic s, input int idx);
    exp_t e;
    e.is_step = 1'b0; e.seed = s; e.waddr = addr_of(idx);
    sb.push_back(e);
  endtask

  task automatic exp_dump(input logic [N-1:0] board, input int cells);
    exp_t e;
    e.is_step = 1'b1; e.seed = 1'b0; e.waddr = '0;
    sb.push_back(e);
    for (int i = 0; i < cells; i++) exp_cell(board[i], i);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && life_step) begin
      if (sb.size() == 0) begin
        check("unexpected_step", 32'(life_step), 32'd0);
      end else begin
        e = sb.pop_front();
        $display("step   gen_count=%0d", gen_count);
        check("step_kind", 32'(e.is_step), 32'd1);
      end
    end
    if (rst_n && seed_ena) begin
      if (sb.size() == 0) begin
        check("unexpected_cell", 32'(seed_ena), 32'd0);
      end else begin
        e = sb.pop_front();
        $display("cell   seed=%0d waddr=%0d wdata=%h", seed, waddr, wdata);
        check("cell_kind", 32'(e.is_step), 32'd0);
        check("seed", 32'(seed), 32'(e.seed));
        check("waddr", 32'(waddr), 32'(e.waddr));
        check("wdata", 32'(wdata), 32'(e.seed ? LIVE : DEAD));
        check("wr", 32'(wr), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vs(input int hi, input int lo);
    vsync = 1'b1; tick(hi);
    vsync = 1'b0; tick(lo);
  endtask

  task automatic send(input logic [7:0] b, input int hi, input int lo);
    rx_byte = b; rx_ready = 1'b1; tick(hi);
    rx_ready = 1'b0; tick(lo);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check("idle_timeout", 32'(ok), 32'd1);
    tick(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seed_ena"}, 32'(seed_ena), 32'd0);
    check({tag, "_seed"}, 32'(seed), 32'd0);
    check({tag, "_wr"}, 32'(wr), 32'd0);
    check({tag, "_life_step"}, 32'(life_step), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(rx_overrun), 32'd0);
    check({tag, "_waddr"}, 32'(waddr), 32'd4);
    check({tag, "_gen"}, 32'(gen_count), 32'd0);
    check({tag, "_pop"}, 32'(pop_count), 32'd0);
  endtask

  initial begin
    bit seen;
    #1 check_reset_outputs("reset");
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Edge 3 is due while the filtered buttons are still high: one auto step of an empty torus.
    exp_dump('0, N);
    repeat (3) vs(4, 4);
    wait_idle();
    check("load_clear_gen", 32'(gen_count), 32'd0);

    // Row padding: "*-*\n" then '*' on row 1.
    exp_cell(1'b1, 0); exp_cell(1'b0, 1); exp_cell(1'b1, 2);
    for (int i = 3; i < 8; i++) exp_cell(1'b0, i);
    send(8'h2A, 3, 7); send(8'h2D, 3, 7); send(8'h2A, 3, 7); send(8'h0A, 3, 7);
    wait_idle();
    exp_cell(1'b1, 8);
    send(8'h2A, 3, 7);
    for (int i = 9; i < N; i++) exp_cell(1'b0, i);
    send(8'h21, 3, 7);
    wait_idle();
    send(8'h21, 3, 7);   // index already 0: nothing
    send(8'h78, 3, 7);   // unknown byte: nothing
    tick(4);
    check("overrun_clear", 32'(rx_overrun), 32'd0);
    check("row_board_drain", 32'(sb.size()), 32'd0);

    // Board fill with two bytes arriving during the 31-cell pad; the second is dropped.
    exp_cell(1'b1, 0);
    send(8'h2A, 3, 7);
    for (int i = 1; i < N; i++) exp_cell(1'b0, i);
    exp_cell(1'b0, 0);
    send(8'h21, 3, 3); send(8'h2D, 3, 3); send(8'h2A, 3, 3);
    wait_idle();
    tick(5);
    check("overrun_set", 32'(rx_overrun), 32'd1);
    exp_cell(1'b1, 1); exp_cell(1'b1, 2);
    send(8'h2A, 3, 7); send(8'h2A, 3, 7);
    for (int i = 3; i < N; i++) exp_cell(1'b0, i);
    send(8'h21, 3, 7);
    wait_idle();
    check("fill_drain", 32'(sb.size()), 32'd0);

    // Leave load mode (edge 6 due is dropped in LOAD), stay paused (edge 9 no step).
    load_n = 1'b1;
    repeat (6) vs(4, 4);
    check("paused_no_step", 32'(sb.size()), 32'd0);
    check("paused_gen", 32'(gen_count), 32'd0);

    // Single step at edge 12 (also due); a second press at edge 18 lands inside DUMP.
    step_n = 1'b0;
    exp_dump(32'h0000_0006, N);
    repeat (3) vs(4, 4);
    step_n = 1'b1;
    repeat (3) vs(2, 2);
    step_n = 1'b0;
    repeat (3) vs(2, 2);
    wait_idle();
    check("single_gen", 32'(gen_count), 32'(stat(1)));
    check("single_pop", 32'(pop_count), 32'(stat(2)));
    check("single_drain", 32'(sb.size()), 32'd0);

    // Automatic stepping: pause released at edge 21, steps at edges 24 and 27.
    pause_n = 1'b1;
    repeat (3) vs(4, 4);
    check("unpause_no_step", 32'(sb.size()), 32'd0);
    exp_dump(32'h0000_0006, N);
    repeat (3) vs(8, 8);
    exp_dump(32'h0000_0006, N);
    repeat (3) vs(8, 8);
    wait_idle();
    check("auto_gen", 32'(gen_count), 32'(stat(3)));
    check("auto_pop", 32'(pop_count), 32'(stat(2)));
    check("auto_drain", 32'(sb.size()), 32'd0);

    // Reset in dump cycle 10 of the step at edge 30.
    repeat (2) vs(8, 8);
    exp_dump(32'h0000_0006, 10);
    vsync = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (life_step) begin seen = 1'b1; break; end
    end
    check("step30_seen", 32'(seen), 32'd1);
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    vsync = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("final_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
